// File: rtl/store_write_buffer_pkg.sv
// Shared types and sizes for the post-commit store write buffer.
package store_write_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_MBE_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] wdata;
    logic [SB_MBE_W-1:0]  mbe;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_t;

endpackage

// File: rtl/store_write_buffer_addr_match.sv
// DEPTH-wide word-address comparator: flags every valid entry whose word address matches.
module store_write_buffer_addr_match
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned WORD_W = SB_ADDR_W - 2
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][WORD_W-1:0] words,
  input  logic [WORD_W-1:0]            word,
  output logic [DEPTH-1:0]             hit
);

  // Per-entry equality on the word address, qualified by entry valid.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = valid[i] && (words[i] == word);
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Post-commit store FIFO: accepts retired stores from the ROB and drains them in order
// to the dcache, one outstanding write at a time. Also flags loads hitting a pending store.
// Optional feature macro: STORE_COALESCE_EN (merge a push into the youngest matching
// queued entry that is not the write currently in flight).
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [SB_DATA_W-1:0] st_wdata,
  input  logic [SB_MBE_W-1:0]  st_mbe,
  output logic                 st_ready,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [SB_DATA_W-1:0] mem_wdata,
  output logic [SB_MBE_W-1:0]  mem_byte_enable,
  input  logic                 mem_resp,
  input  logic [ADDR_W-1:0]    ld_addr,
  output logic                 ld_conflict,
  output logic                 sb_empty
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned WORD_W = ADDR_W - 2;

  sb_entry_t               entries [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_nxt;
  sb_state_t               state;
  sb_state_t               state_nxt;
  logic                    push;
  logic                    pop;
  logic                    alloc;
  sb_entry_t               new_entry;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][WORD_W-1:0] ent_word;
  logic [DEPTH-1:0]        ld_hit;
  logic                    unused_ld_offset;

  assign st_ready  = (count != CNT_W'(DEPTH));
  assign push      = st_valid && st_ready;
  assign pop       = (state == SB_WRITE) && mem_resp;
  assign count_nxt = count + CNT_W'(alloc) - CNT_W'(pop);

  // Low load-address bits are a byte offset; the probe compares whole words.
  assign unused_ld_offset = ^ld_addr[1:0];

  // Flatten entry valid bits and word addresses for the comparators.
  always_comb begin
    ent_valid = '0;
    ent_word  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_valid[i] = entries[i].valid;
      ent_word[i]  = entries[i].addr[ADDR_W-1:2];
    end
  end

  store_write_buffer_addr_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_ld_match (
    .valid (ent_valid),
    .words (ent_word),
    .word  (ld_addr[ADDR_W-1:2]),
    .hit   (ld_hit)
  );

  assign ld_conflict = |ld_hit;

`ifdef STORE_COALESCE_EN
  logic [DEPTH-1:0] st_hit;
  logic [DEPTH-1:0] st_cand;
  logic             merge;
  logic [PTR_W-1:0] merge_idx;

  store_write_buffer_addr_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_st_match (
    .valid (ent_valid),
    .words (ent_word),
    .word  (st_addr[ADDR_W-1:2]),
    .hit   (st_hit)
  );

  // Youngest matching entry, scanning oldest to youngest; in-flight head never merges.
  always_comb begin
    st_cand = st_hit;
    if (state == SB_WRITE) begin
      st_cand[head] = 1'b0;
    end
    merge     = 1'b0;
    merge_idx = head;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (st_cand[head + PTR_W'(k)]) begin
        merge     = 1'b1;
        merge_idx = head + PTR_W'(k);
      end
    end
  end

  assign alloc = push && !merge;
`else
  assign alloc = push;
`endif

  // Incoming store packed into an entry.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.addr  = st_addr;
    new_entry.wdata = st_wdata;
    new_entry.mbe   = st_mbe;
  end

  // Entry storage and ring pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (alloc) begin
        entries[tail] <= new_entry;
        tail          <= tail + PTR_W'(1);
      end
`ifdef STORE_COALESCE_EN
      if (push && merge) begin
        for (int b = 0; b < int'(SB_MBE_W); b++) begin
          if (st_mbe[b]) begin
            entries[merge_idx].wdata[8*b +: 8] <= st_wdata[8*b +: 8];
          end
        end
        entries[merge_idx].mbe <= entries[merge_idx].mbe | st_mbe;
      end
`endif
      count <= count_nxt;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain FSM next state: start a write once anything is queued, stay busy while work remains.
  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE:  if (count_nxt != '0) state_nxt = SB_WRITE;
      SB_WRITE: if (pop && (count_nxt == '0)) state_nxt = SB_IDLE;
      default:  state_nxt = SB_IDLE;
    endcase
  end

  // Write request presents the head entry while writing; zeros otherwise.
  always_comb begin
    mem_write       = (state == SB_WRITE);
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    if (state == SB_WRITE) begin
      mem_address     = entries[head].addr;
      mem_wdata       = entries[head].wdata;
      mem_byte_enable = entries[head].mbe;
    end
  end

  assign sb_empty = (count == '0) && (state == SB_IDLE);

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: vector table for single stores plus
// hand sequences for fill, push+pop overlap, coalescing (STORE_COALESCE_EN) and reset.
module tb_store_write_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_mbe;
  logic        st_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mbe;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mbe;
    int          hold;
    logic [31:0] probe;
    logic        exp_hit;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[5];

  store_write_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_wdata        (st_wdata),
    .st_mbe          (st_mbe),
    .st_ready        (st_ready),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .ld_addr         (ld_addr),
    .ld_conflict     (ld_conflict),
    .sb_empty        (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // One-cycle push; expectation queued when the store is expected to produce its own write.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit exp_write);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_mbe   = m;
    if (exp_write) sb.push_back('{addr: a, data: d, mbe: m});
    tick();
    st_valid = 1'b0;
  endtask

  // Scoreboard: every completed write handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mem_write && mem_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_write", mem_address, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_address, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_mbe", {28'd0, mem_byte_enable}, {28'd0, e.mbe});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0100, data: 32'hDEAD_BEEF, mbe: 4'hF, hold: 5, probe: 32'h0000_0100, exp_hit: 1'b1};
    vecs[1] = '{addr: 32'h0000_0204, data: 32'h1234_5678, mbe: 4'h3, hold: 2, probe: 32'h0000_0206, exp_hit: 1'b1};
    vecs[2] = '{addr: 32'h0000_0204, data: 32'hA5A5_A5A5, mbe: 4'hC, hold: 0, probe: 32'h0000_0208, exp_hit: 1'b0};
    vecs[3] = '{addr: 32'hFFFF_FFFC, data: 32'h0102_0304, mbe: 4'h1, hold: 1, probe: 32'hFFFF_FFFF, exp_hit: 1'b1};
    vecs[4] = '{addr: 32'h0000_0000, data: 32'h0000_0000, mbe: 4'h0, hold: 3, probe: 32'h0000_0004, exp_hit: 1'b0};

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_mbe = '0;
    mem_resp = 1'b0; ld_addr = '0;

    // Reset values
    #3;
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("rst_ld_conflict", {31'd0, ld_conflict}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    settle();
    rst = 1'b0;
    tick();

    // Single stores: request next cycle, stable while stalled, empty after response
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].addr, vecs[i].data, vecs[i].mbe, 1'b1);
      ld_addr = vecs[i].probe;
      settle();
      check($sformatf("v%0d_mem_write", i), {31'd0, mem_write}, 32'd1);
      check($sformatf("v%0d_addr", i), mem_address, vecs[i].addr);
      check($sformatf("v%0d_conflict", i), {31'd0, ld_conflict}, {31'd0, vecs[i].exp_hit});
      check($sformatf("v%0d_not_empty", i), {31'd0, sb_empty}, 32'd0);
      for (int h = 0; h < vecs[i].hold; h++) begin
        tick();
        settle();
        check($sformatf("v%0d_hold_wr", i), {31'd0, mem_write}, 32'd1);
        check($sformatf("v%0d_hold_data", i), mem_wdata, vecs[i].data);
      end
      tick();
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      settle();
      check($sformatf("v%0d_empty", i), {31'd0, sb_empty}, 32'd1);
      check($sformatf("v%0d_drained_conflict", i), {31'd0, ld_conflict}, 32'd0);
      tick();
    end

    // Fill to DEPTH, overflow push ignored, back-to-back in-order drain
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1);
    settle();
    check("full_st_ready", {31'd0, st_ready}, 32'd0);
    tick();
    push(32'h0000_0200, 32'hBAD0_BAD0, 4'hF, 1'b0);
    ld_addr = 32'h0000_0200;
    settle();
    check("overflow_ignored", {31'd0, ld_conflict}, 32'd0);
    check("full_still", {31'd0, st_ready}, 32'd0);
    tick();
    mem_resp = 1'b1;
    settle();
    check("no_pushthrough", {31'd0, st_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_wr%0d", k), {31'd0, mem_write}, 32'd1);
      tick();
      if (k == 0) check("ready_after_pop", {31'd0, st_ready}, 32'd1);
      settle();
    end
    mem_resp = 1'b0;
    check("fill_empty", {31'd0, sb_empty}, 32'd1);
    tick();

    // Push and pop in the same cycle at count=2
    push(32'h400, 32'h4000_0000, 4'hF, 1'b1);
    push(32'h404, 32'h4000_0004, 4'hF, 1'b1);
    mem_resp = 1'b1;
    push(32'h408, 32'h4000_0008, 4'hF, 1'b1);
    mem_resp = 1'b0;
    settle();
    check("overlap_head", mem_address, 32'h404);
    tick();
    push(32'h40C, 32'h4000_000C, 4'hF, 1'b1);
    settle();
    check("overlap_cnt3_ready", {31'd0, st_ready}, 32'd1);
    tick();
    push(32'h410, 32'h4000_0010, 4'hF, 1'b1);
    settle();
    check("overlap_cnt4_full", {31'd0, st_ready}, 32'd0);
    tick();
    mem_resp = 1'b1;
    repeat (4) tick();
    mem_resp = 1'b0;
    settle();
    check("overlap_empty", {31'd0, sb_empty}, 32'd1);
    tick();

    // Same-word pushes behind an in-flight write
`ifdef STORE_COALESCE_EN
    push(32'h300, 32'hAAAA_AAAA, 4'hF, 1'b1);
    push(32'h304, 32'h0000_0011, 4'h1, 1'b0);
    push(32'h304, 32'h0022_0000, 4'h4, 1'b0);
    sb.push_back('{addr: 32'h304, data: 32'h0022_0011, mbe: 4'h5});
    push(32'h300, 32'hBBBB_BBBB, 4'hF, 1'b1);
    mem_resp = 1'b1;
    repeat (3) tick();
`else
    push(32'h300, 32'hAAAA_AAAA, 4'hF, 1'b1);
    push(32'h304, 32'h0000_0011, 4'h1, 1'b1);
    push(32'h304, 32'h0022_0000, 4'h4, 1'b1);
    push(32'h300, 32'hBBBB_BBBB, 4'hF, 1'b1);
    mem_resp = 1'b1;
    repeat (4) tick();
`endif
    mem_resp = 1'b0;
    settle();
    check("merge_empty", {31'd0, sb_empty}, 32'd1);
    check("merge_drained", 32'(sb.size()), 32'd0);
    tick();

    // Asynchronous reset in the middle of a write drops everything
    push(32'h500, 32'h5000_0000, 4'hF, 1'b0);
    push(32'h504, 32'h5000_0004, 4'hF, 1'b0);
    ld_addr = 32'h500;
    #2;
    rst = 1'b1;
    #1;
    check("arst_mem_write", {31'd0, mem_write}, 32'd0);
    check("arst_st_ready", {31'd0, st_ready}, 32'd1);
    check("arst_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("arst_conflict", {31'd0, ld_conflict}, 32'd0);
    tick();
    settle();
    rst = 1'b0;
    tick();
    push(32'h600, 32'h6000_0000, 4'h9, 1'b1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    settle();
    check("post_rst_empty", {31'd0, sb_empty}, 32'd1);
    check("final_drained", 32'(sb.size()), 32'd0);
    check("final_idle", {31'd0, mem_write}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
